// File: rtl/jtkicker_mainio_pkg.sv
// jtkicker_mainio_pkg: latch bit positions, cabinet row encoding and helpers
package jtkicker_mainio_pkg;
  localparam int FLIP   = 0;
  localparam int SNDIRQ = 1;
  localparam int COIN1  = 3;
  localparam int COIN2  = 4;
  typedef enum logic [1:0] {ROW_SYS, ROW_P12, ROW_P34, ROW_DIP} row_e;
  function automatic logic [2:0] rev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction
endpackage

// File: rtl/jtkicker_mainio_if.sv
// jtkicker_mainio_if: CPU-side bus into the cabinet I/O block
interface jtkicker_mainio_if;
  logic       cpu_cen;
  logic [2:0] addr;
  logic       rnw;
  logic [7:0] cpu_dout;
  logic       iow_cs;
  logic       ior_cs;
  logic       wdog_cs;
  logic [7:0] cab_dout;
  modport master (output cpu_cen, addr, rnw, cpu_dout, iow_cs, ior_cs, wdog_cs, input cab_dout);
  modport slave  (input cpu_cen, addr, rnw, cpu_dout, iow_cs, ior_cs, wdog_cs, output cab_dout);
endinterface

// File: rtl/jtkicker_frmcnt.sv
// jtkicker_frmcnt: edge-driven modulo-N counter with clear and registered terminal pulse
module jtkicker_frmcnt #(
  parameter int N = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic tc_o
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap, tc_d;
  always_comb begin
    wrap  = (N > 0) && inc_i && (cnt_q == W'(N - 1));
    cnt_d = (clr_i || wrap) ? '0 : inc_i ? cnt_q + W'(1) : cnt_q;
    tc_d  = wrap && !clr_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tc_o  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_o  <= tc_d;
    end
  end
endmodule

// File: rtl/jtkicker_mainio.sv
// jtkicker_mainio: cabinet inputs, 74LS259 output latch, VBLANK IRQ/NMI and watchdog
module jtkicker_mainio
  import jtkicker_mainio_pkg::*;
#(
  parameter int NPLAYERS    = 2,
  parameter int NMI_DIV     = 0,
  parameter int WDOG_FRAMES = 0,
  parameter int IRQ_BIT     = 7,
  parameter int NMI_BIT     = 6
) (
  input  logic                clk,
  input  logic                rst,
  jtkicker_mainio_if.slave    bus,
  input  logic [3:0]          start_button,
  input  logic [3:0]          coin_input,
  input  logic [6:0]          joystick1,
  input  logic [6:0]          joystick2,
  input  logic [6:0]          joystick3,
  input  logic [6:0]          joystick4,
  input  logic                service,
  input  logic [7:0]          dipsw_a,
  input  logic                LVBL,
  input  logic                dip_pause,
  output logic [7:0]          latch,
  output logic                flip,
  output logic                snd_irq,
  output logic [1:0]          coin_cnt,
  output logic                irq_n,
  output logic                nmi_n,
  output logic                wdog_rst
);
  logic [7:0] latch_q, latch_d, cab_q, cab_d;
  logic [3:0] st;
  logic       lvbl_q, arm_q, irq_q, irq_d, nmi_q, nmi_d;
  logic       fall, vb, kick, nmi_tc;
  row_e       row;
  logic       unused_ok;
  assign unused_ok = &{1'b0, bus.ior_cs, coin_input[3:2], joystick1[3:0], joystick2[3:0],
                       joystick3[3:0], joystick4[3:0]};
  // arm_q masks the first cycle after reset so a low LVBL at release is not an edge
  assign fall = arm_q && lvbl_q && !LVBL;
  assign vb   = fall && dip_pause;
  assign kick = bus.cpu_cen && bus.wdog_cs && !bus.rnw;
  assign row  = row_e'(bus.addr[1:0]);
  assign st   = NPLAYERS == 4 ? start_button : {2'b11, start_button[1:0]};
  always_comb begin
    latch_d = latch_q;
    if (bus.cpu_cen && bus.iow_cs && !bus.rnw) latch_d[bus.addr] = bus.cpu_dout[0];
    irq_d = !latch_d[IRQ_BIT] ? 1'b0 : (vb || irq_q);
    nmi_d = !latch_d[NMI_BIT] ? 1'b0 : (nmi_tc || nmi_q);
    cab_d = row == ROW_SYS ? {3'b111, st[1:0], service, coin_input[1:0]} :
            row == ROW_P12 ? {1'b1, rev3(joystick2[6:4]), st[2], rev3(joystick1[6:4])} :
            row == ROW_P34 ? (NPLAYERS == 4 ? {1'b1, rev3(joystick4[6:4]), st[3], rev3(joystick3[6:4])} : 8'hFF) :
                             dipsw_a;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q <= '0;
      cab_q   <= 8'hFF;
      lvbl_q  <= 1'b1;
      arm_q   <= 1'b0;
      irq_q   <= 1'b0;
      nmi_q   <= 1'b0;
    end else begin
      latch_q <= latch_d;
      cab_q   <= cab_d;
      lvbl_q  <= LVBL;
      arm_q   <= 1'b1;
      irq_q   <= irq_d;
      nmi_q   <= nmi_d;
    end
  end
  jtkicker_frmcnt #(.N(NMI_DIV)) u_nmi (
    .clk(clk), .rst(rst), .inc_i(vb), .clr_i(1'b0), .tc_o(nmi_tc)
  );
  jtkicker_frmcnt #(.N(WDOG_FRAMES)) u_wdog (
    .clk(clk), .rst(rst), .inc_i(fall), .clr_i(kick), .tc_o(wdog_rst)
  );
  assign bus.cab_dout = cab_q;
  assign latch        = latch_q;
  assign flip         = latch_q[FLIP];
  assign snd_irq      = latch_q[SNDIRQ];
  assign coin_cnt     = {latch_q[COIN2], latch_q[COIN1]};
  assign irq_n        = ~irq_q;
  assign nmi_n        = ~nmi_q;
endmodule

// File: tb/tb_jtkicker_mainio.sv
// tb_jtkicker_mainio: directed stimulus with a queued-expectation scoreboard on two configurations
module tb_jtkicker_mainio;
  logic clk, rst;
  logic [3:0] start_button, coin_input;
  logic [6:0] joystick1, joystick2, joystick3, joystick4;
  logic service, LVBL, dip_pause;
  logic [7:0] dipsw_a;
  logic [7:0] latch_a, latch_b;
  logic flip_a, snd_a, irq_a, nmi_a, wdog_a, flip_b, snd_b, irq_b, nmi_b, wdog_b;
  logic [1:0] coin_a, coin_b;
  int cyc = 0, checks = 0, passes = 0;
  typedef struct {int due; int id; logic [7:0] v; string nm;} item_t;
  item_t q[$];
  jtkicker_mainio_if bif_a();
  jtkicker_mainio_if bif_b();
  assign bif_b.cpu_cen  = bif_a.cpu_cen;
  assign bif_b.addr     = bif_a.addr;
  assign bif_b.rnw      = bif_a.rnw;
  assign bif_b.cpu_dout = bif_a.cpu_dout;
  assign bif_b.iow_cs   = bif_a.iow_cs;
  assign bif_b.ior_cs   = bif_a.ior_cs;
  assign bif_b.wdog_cs  = bif_a.wdog_cs;
  jtkicker_mainio #(.NPLAYERS(2), .NMI_DIV(4), .WDOG_FRAMES(3)) dut_a (
    .clk(clk), .rst(rst), .bus(bif_a), .start_button(start_button), .coin_input(coin_input),
    .joystick1(joystick1), .joystick2(joystick2), .joystick3(joystick3), .joystick4(joystick4),
    .service(service), .dipsw_a(dipsw_a), .LVBL(LVBL), .dip_pause(dip_pause),
    .latch(latch_a), .flip(flip_a), .snd_irq(snd_a), .coin_cnt(coin_a),
    .irq_n(irq_a), .nmi_n(nmi_a), .wdog_rst(wdog_a));
  jtkicker_mainio #(.NPLAYERS(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bif_b), .start_button(start_button), .coin_input(coin_input),
    .joystick1(joystick1), .joystick2(joystick2), .joystick3(joystick3), .joystick4(joystick4),
    .service(service), .dipsw_a(dipsw_a), .LVBL(LVBL), .dip_pause(dip_pause),
    .latch(latch_b), .flip(flip_b), .snd_irq(snd_b), .coin_cnt(coin_b),
    .irq_n(irq_b), .nmi_n(nmi_b), .wdog_rst(wdog_b));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] obs(input int id);
    case (id)
      0: return bif_a.cab_dout;
      1: return latch_a;
      2: return {7'd0, irq_a};
      3: return {7'd0, nmi_a};
      4: return {7'd0, wdog_a};
      5: return bif_b.cab_dout;
      default: return {4'd0, coin_a, snd_a, flip_a};
    endcase
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin : pop
      item_t it;
      logic [7:0] got;
      it = q.pop_front();
      got = obs(it.id);
      checks++;
      if (got === it.v) passes++;
      else $display("FAIL %s: got %02h expected %02h (cycle %0d)", it.nm, got, it.v, cyc);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic exp(input int id, input logic [7:0] v, input string nm);
    item_t it;
    it.due = cyc + 1; it.id = id; it.v = v; it.nm = nm;
    q.push_back(it);
  endtask
  task automatic wr(input logic [2:0] a, input logic d);
    bif_a.addr = a; bif_a.cpu_dout = {7'd0, d};
    bif_a.cpu_cen = 1; bif_a.iow_cs = 1; bif_a.rnw = 0;
    tick;
    bif_a.cpu_cen = 0; bif_a.iow_cs = 0; bif_a.rnw = 1;
  endtask
  task automatic kick;
    bif_a.cpu_cen = 1; bif_a.wdog_cs = 1; bif_a.rnw = 0;
    tick;
    bif_a.cpu_cen = 0; bif_a.wdog_cs = 0; bif_a.rnw = 1;
  endtask
  task automatic idle_cab;
    start_button = 4'hF; coin_input = 4'hF; service = 1;
    joystick1 = 7'h7F; joystick2 = 7'h7F; joystick3 = 7'h7F; joystick4 = 7'h7F;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1; LVBL = 1; dip_pause = 1; dipsw_a = 8'hA5; idle_cab();
    bif_a.cpu_cen = 0; bif_a.addr = 3'd0; bif_a.rnw = 1; bif_a.cpu_dout = 8'h00;
    bif_a.iow_cs = 0; bif_a.ior_cs = 0; bif_a.wdog_cs = 0;
    tick;
    exp(0, 8'hFF, "rst_cab"); exp(1, 8'h00, "rst_latch"); exp(2, 8'h01, "rst_irq_n");
    exp(3, 8'h01, "rst_nmi_n"); exp(4, 8'h00, "rst_wdog"); exp(6, 8'h00, "rst_pins");
    tick;
    rst = 0;
    bif_a.addr = 3'd3; exp(0, 8'hA5, "row_dip"); exp(5, 8'hA5, "row_dip_4p"); tick;
    bif_a.addr = 3'd0; start_button = 4'b1110; service = 0; coin_input = 4'b1101;
    exp(0, 8'hF1, "row_sys"); tick;
    bif_a.addr = 3'd1; start_button = 4'b1011; joystick1 = 7'b1101111; joystick2 = 7'b1011111;
    exp(0, 8'hDB, "row_p12_2p"); exp(5, 8'hD3, "row_p12_4p"); tick;
    bif_a.addr = 3'd2; joystick3 = 7'h00;
    exp(0, 8'hFF, "row_p34_2p"); exp(5, 8'hF8, "row_p34_4p"); tick;
    idle_cab(); bif_a.addr = 3'd0; tick;
    exp(1, 8'h80, "latch_irq_en"); wr(3'd7, 1'b1);
    LVBL = 0; exp(2, 8'h00, "irq_set"); tick;
    LVBL = 1; exp(2, 8'h00, "irq_hold"); tick;
    exp(2, 8'h01, "irq_clr"); exp(1, 8'h00, "latch_irq_dis"); wr(3'd7, 1'b0);
    wr(3'd0, 1'b1); wr(3'd3, 1'b1);
    exp(6, 8'h0D, "pins_flip_coin"); exp(1, 8'h19, "latch_aux"); wr(3'd4, 1'b1);
    exp(6, 8'h0F, "pins_snd"); wr(3'd1, 1'b1);
    for (int a = 0; a < 8; a++) begin
      if (a == 7) exp(1, 8'hFF, "latch_all");
      wr(3'(a), 1'b1);
    end
    LVBL = 0; exp(2, 8'h00, "irq_pre_rst"); tick;
    bif_a.addr = 3'd3; rst = 1;
    exp(0, 8'hFF, "mid_rst_cab"); exp(1, 8'h00, "mid_rst_latch"); exp(2, 8'h01, "mid_rst_irq_n");
    exp(3, 8'h01, "mid_rst_nmi_n"); exp(4, 8'h00, "mid_rst_wdog"); exp(6, 8'h00, "mid_rst_pins");
    tick; tick;
    rst = 0; exp(0, 8'hA5, "post_rst_cab"); tick; tick;
    LVBL = 1; tick;
    wr(3'd6, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      LVBL = 0; exp(3, 8'h01, "nmi_edge"); tick;
      LVBL = 1; exp(3, (i % 4 == 0) ? 8'h00 : 8'h01, "nmi_frame"); tick;
      if (i % 4 == 0) begin
        exp(3, 8'h01, "nmi_clr"); wr(3'd6, 1'b0);
        wr(3'd6, 1'b1);
      end
    end
    kick();
    for (int i = 1; i <= 3; i++) begin
      LVBL = 0; exp(4, (i == 3) ? 8'h01 : 8'h00, "wdog_edge"); tick;
      LVBL = 1; exp(4, 8'h00, "wdog_one_cycle"); tick;
    end
    for (int i = 1; i <= 2; i++) begin
      LVBL = 0; tick; LVBL = 1; tick;
    end
    LVBL = 0; bif_a.cpu_cen = 1; bif_a.wdog_cs = 1; bif_a.rnw = 0;
    exp(4, 8'h00, "wdog_kick_wins"); tick;
    bif_a.cpu_cen = 0; bif_a.wdog_cs = 0; bif_a.rnw = 1;
    LVBL = 1; exp(4, 8'h00, "wdog_kick_quiet"); tick;
    for (int i = 1; i <= 3; i++) begin
      LVBL = 0; exp(4, (i == 3) ? 8'h01 : 8'h00, "wdog_after_kick"); tick;
      LVBL = 1; tick;
    end
    kick();
    wr(3'd7, 1'b1);
    dip_pause = 0;
    for (int i = 1; i <= 3; i++) begin
      LVBL = 0; exp(2, 8'h01, "irq_paused"); exp(4, (i == 3) ? 8'h01 : 8'h00, "wdog_paused"); tick;
      LVBL = 1; exp(2, 8'h01, "irq_paused_hi"); tick;
    end
    dip_pause = 1;
    LVBL = 0; exp(2, 8'h00, "irq_resume"); tick;
    LVBL = 1; tick;
    for (int k = 0; k < 20 && q.size() > 0; k++) tick;
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations pending, required 0", q.size());
      checks += q.size();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
